// File: rtl/i2s_receiver_if.sv
// Stereo pair hand-off between the I2S receiver (master side) and the audio datapath (slave side).
interface i2s_receiver_if #(
  parameter int WIDTH = 16
) ();
  logic [WIDTH-1:0] left_sample;
  logic [WIDTH-1:0] right_sample;
  logic             pair_valid;
  logic             pair_ready;

  modport master (
    output left_sample,
    output right_sample,
    output pair_valid,
    input  pair_ready
  );

  modport slave (
    input  left_sample,
    input  right_sample,
    input  pair_valid,
    output pair_ready
  );
endinterface

// File: rtl/i2s_receiver.sv
// I2S slave receiver: oversamples LRCLK/SCLK/SD in the MCLK domain, deserialises MSB-first words
// with the one-bit I2S delay and presents left/right pairs through a valid/ready holding register.
module i2s_receiver #(
  parameter int WIDTH = 16
) (
  input  logic           MCLK,
  input  logic           resetN,
  input  logic           onOff,
  input  logic           LRCLK,
  input  logic           SCLK,
  input  logic           SD,
  input  logic           clear_err,
  output logic           overrun,
  output logic           frame_err,
  i2s_receiver_if.master pair
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    UNSYNCED  = 2'd0,
    CAPTURE   = 2'd1,
    DONE_SLOT = 2'd2
  } state_t;

  logic r_sckMeta, r_sckSync, r_sckDly;
  logic r_sdMeta, r_sdSync;
  logic r_lrMeta, r_lrSync;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_leftStage;
  logic             r_leftValid;
  logic             r_chan;
  logic             r_lrPrev;

  logic             w_sckRise;
  logic             w_wsChange;
  logic [WIDTH-1:0] w_shiftNext;
  logic [CW-1:0]    w_cntNext;
  logic             w_bitTaken;
  logic             w_wordDone;
  logic             w_shortSlot;
  logic             w_leftDone;
  logic             w_rightDone;
  logic             w_pairDone;

  // SD and LRCLK share the 2-FF depth of SCLK so bit alignment survives synchronisation.
  always_ff @(posedge MCLK) begin
    if (!resetN) begin
      r_sckMeta <= 1'b0;
      r_sckSync <= 1'b0;
      r_sckDly  <= 1'b0;
      r_sdMeta  <= 1'b0;
      r_sdSync  <= 1'b0;
      r_lrMeta  <= 1'b0;
      r_lrSync  <= 1'b0;
    end else begin
      r_sckMeta <= SCLK;
      r_sckSync <= r_sckMeta;
      r_sckDly  <= r_sckSync;
      r_sdMeta  <= SD;
      r_sdSync  <= r_sdMeta;
      r_lrMeta  <= LRCLK;
      r_lrSync  <= r_lrMeta;
    end
  end

  always_comb begin
    w_sckRise   = r_sckSync & ~r_sckDly;
    w_wsChange  = w_sckRise & (r_lrSync != r_lrPrev);
    w_shiftNext = {r_shift[WIDTH-2:0], r_sdSync};
    w_cntNext   = r_cnt + CW'(1);
    w_bitTaken  = onOff & w_sckRise & (r_state == CAPTURE);
    w_wordDone  = w_bitTaken & (w_cntNext == CW'(WIDTH));
    w_shortSlot = onOff & w_wsChange & (r_state == CAPTURE) & (w_cntNext != CW'(WIDTH));
    w_leftDone  = w_wordDone & ~r_chan;
    w_rightDone = w_wordDone & r_chan;
    w_pairDone  = w_rightDone & r_leftValid;
  end

  // r_lrPrev keeps tracking while disabled so re-enable never sees a stale word-select change.
  always_ff @(posedge MCLK) begin
    if (!resetN) begin
      r_state           <= UNSYNCED;
      r_cnt             <= '0;
      r_shift           <= '0;
      r_leftStage       <= '0;
      r_leftValid       <= 1'b0;
      r_chan            <= 1'b0;
      r_lrPrev          <= 1'b0;
      pair.left_sample  <= '0;
      pair.right_sample <= '0;
      pair.pair_valid   <= 1'b0;
      overrun           <= 1'b0;
      frame_err         <= 1'b0;
    end else begin
      if (w_sckRise) begin
        r_lrPrev <= r_lrSync;
      end

      if (!onOff) begin
        r_state     <= UNSYNCED;
        r_cnt       <= '0;
        r_shift     <= '0;
        r_leftStage <= '0;
        r_leftValid <= 1'b0;
      end else if (w_sckRise) begin
        if (w_leftDone) begin
          r_leftStage <= w_shiftNext;
          r_leftValid <= 1'b1;
        end
        if (w_rightDone || w_shortSlot) begin
          r_leftValid <= 1'b0;
        end
        if (w_wsChange) begin
          r_state <= CAPTURE;
          r_cnt   <= '0;
          r_shift <= '0;
          r_chan  <= r_lrSync;
          if (!r_lrSync) begin
            r_leftValid <= 1'b0;
          end
        end else if (r_state == CAPTURE) begin
          r_shift <= w_shiftNext;
          r_cnt   <= w_cntNext;
          if (w_wordDone) begin
            r_state <= DONE_SLOT;
          end
        end
      end

      // A completing pair always wins over acceptance, so valid stays high when both coincide.
      if (w_pairDone) begin
        pair.left_sample  <= r_leftStage;
        pair.right_sample <= w_shiftNext;
        pair.pair_valid   <= 1'b1;
      end else if (pair.pair_valid && pair.pair_ready) begin
        pair.pair_valid <= 1'b0;
      end

      if (w_pairDone && pair.pair_valid && !pair.pair_ready) begin
        overrun <= 1'b1;
      end else if (clear_err) begin
        overrun <= 1'b0;
      end

      if (w_shortSlot) begin
        frame_err <= 1'b1;
      end else if (clear_err) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule
